inst_fetch_unit: RTL
====================

# inst_fetch_unit

Instruction prefetch stage that sits directly upstream of `exec_unit`. It reads 16-bit instructions as two consecutive bytes from byte-wide RAM, MSB at the lower address, and queues them with their PC in a small FIFO. It presents them to the execution stage over a valid/ready handshake. A redirect input flushes the queue and restarts fetch at a new PC when a jump is taken.

## Interface
Parameters:
- `ADDR_BITS`, default 8: RAM address width; also the PC width.
- `DATA_BITS`, default 8: RAM data width (one byte per read).
- `FIFO_DEPTH`, default 2: instruction queue entries; must be a power of two and at least 2.
- `RESET_PC`, default 0: first fetch address after reset.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rd_ram_en`  out  1  RAM read request for this cycle.
- `rd_ram_addr`  out  ADDR_BITS  RAM read address.
- `rd_ram_data`  in  DATA_BITS  RAM read data; valid in the cycle after the request.
- `mem_busy`  in  1  execution stage owns the RAM read port; blocks the start of a new instruction fetch.
- `inst_valid`  out  1  queue head holds an instruction.
- `inst_data`  out  16  head instruction, {MSB byte, LSB byte}.
- `inst_pc`  out  ADDR_BITS  address of the head instruction's MSB byte.
- `inst_ready`  in  1  consumer accepts the head; a pop occurs when `inst_valid` and `inst_ready` are both high.
- `redirect_en`  in  1  flush request; restart fetch at `redirect_pc`.
- `redirect_pc`  in  ADDR_BITS  new fetch address.

## Operation
- Internal state: `fetch_pc`, a captured MSB byte, the FIFO (data+pc per entry, `count`), and the FSM.
- FSM states and outputs:
  - IDLE: `rd_ram_en`=0. Always goes to REQ_MSB.
  - REQ_MSB:
    - If `mem_busy`=0 and `count` < `FIFO_DEPTH`: `rd_ram_en`=1, `rd_ram_addr`=`fetch_pc`, then go to REQ_LSB.
    - Otherwise: `rd_ram_en`=0 and stay in REQ_MSB.
  - REQ_LSB: capture `rd_ram_data` as the MSB byte. Drive `rd_ram_en`=1, `rd_ram_addr`=`fetch_pc`+1. Go to PUSH. `mem_busy` is ignored here; a started pair always completes back to back.
  - PUSH: `rd_ram_en`=0. Write {MSB, `rd_ram_data`} with pc=`fetch_pc` into the FIFO. Set `fetch_pc` += 2. Go to REQ_MSB.
- `rd_ram_en` and `rd_ram_addr` are combinational from the state and `fetch_pc`. `rd_ram_addr` is 0 whenever `rd_ram_en`=0.
- The `count` check in REQ_MSB is sufficient because at most one instruction is in flight.
- Address arithmetic is modulo 2^ADDR_BITS:
  - `fetch_pc`=8'hFF reads FF then 00; next `fetch_pc` is 01.
  - `fetch_pc`=8'hFE gives next `fetch_pc` 00.
  - An odd `redirect_pc` is legal and fetches pc, pc+1.
- FIFO behaviour:
  - `inst_valid` = (`count` != 0).
  - `inst_data` and `inst_pc` show the head entry. Both are 0 when `inst_valid`=0.
  - A push and a pop in the same cycle leave `count` unchanged and preserve order.
- Redirect (`redirect_en`=1 in any state) has priority over everything else:
  - That cycle: `rd_ram_en` is forced to 0.
  - Next edge: `count` becomes 0, `fetch_pc` is loaded with `redirect_pc`, state goes to REQ_MSB, and any in-flight pair is discarded without a push.
  - A pop in the same cycle counts as consumed, and the queue is still emptied.
- Reset: `state`=IDLE, `fetch_pc`=`RESET_PC`, `count`=0, FIFO pointers 0.
  - Output reset values: `rd_ram_en`=0, `rd_ram_addr`=0, `inst_valid`=0, `inst_data`=0, `inst_pc`=0.
  - Reset mid-fetch abandons the pair; no partial instruction is ever queued.

## Timing
- Cycle numbering after reset deasserts:
  - Cycle 1: IDLE.
  - Cycle 2: read `RESET_PC`.
  - Cycle 3: read `RESET_PC`+1.
  - Cycle 4: PUSH.
  - Cycle 5: `inst_valid`=1.
- Sustained throughput is one instruction per 3 cycles while the queue has room and `mem_busy`=0.
- After a redirect in cycle n:
  - `inst_valid`=0 from cycle n+1.
  - Read of `redirect_pc` in cycle n+1 (if `mem_busy`=0).
  - `inst_valid`=1 in cycle n+4 at the earliest.
- A pop is visible on the next edge. The freed slot allows an issue in that following cycle.
- `mem_busy` is sampled only in REQ_MSB. Each cycle it stays high delays the issue by exactly one cycle.

## Test plan
- Reset release, RAM[0]=8'h12, RAM[1]=8'h34, `inst_ready`=1 -> `rd_ram_en` high cycles 2–3 at addr 0, 1; `inst_valid`=1, `inst_data`=16'h1234, `inst_pc`=0 in cycle 5.
- `inst_ready`=0 and `FIFO_DEPTH`=2 -> two pushes (pc 0, 2), then REQ_MSB holds with `rd_ram_en`=0. Raising `inst_ready` for one cycle pops 16'h1234, and the fetch of pc 4 starts the next cycle.
- `mem_busy`=1 for 3 cycles during REQ_MSB -> no read for 3 cycles, then the read resumes at the same `fetch_pc`. `mem_busy` raised during REQ_LSB -> the LSB read still happens.
- Queue holding pc 0 and 2, fetch of pc 4 in REQ_LSB, `redirect_en`=1 with `redirect_pc`=8'h40 -> `inst_valid`=0 next cycle, no entry for pc 4, and the next read is addr 8'h40.
- `redirect_pc`=8'hFF -> reads at FF then 00; `inst_pc`=8'hFF; next fetch at 01.
- Assert `reset` during REQ_LSB -> all outputs 0 next cycle, and the restart fetches from `RESET_PC`.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction prefetch: reads 16-bit instructions as two bytes (MSB first) from
// byte-wide RAM into a small PC-tagged queue, with redirect flush.
module inst_fetch_unit #(
    parameter int ADDR_BITS  = 8,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 2,
    parameter logic [ADDR_BITS-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 rd_ram_en,
    output logic [ADDR_BITS-1:0] rd_ram_addr,
    input  logic [DATA_BITS-1:0] rd_ram_data,
    input  logic                 mem_busy,
    output logic                 inst_valid,
    output logic [15:0]          inst_data,
    output logic [ADDR_BITS-1:0] inst_pc,
    input  logic                 inst_ready,
    input  logic                 redirect_en,
    input  logic [ADDR_BITS-1:0] redirect_pc
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]     DEPTH   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0]     PTR_ONE = PTR_W'(1);
    localparam logic [ADDR_BITS-1:0] PC_ONE  = ADDR_BITS'(1);
    localparam logic [ADDR_BITS-1:0] PC_TWO  = ADDR_BITS'(2);

    typedef enum logic [1:0] {IDLE, REQ_MSB, REQ_LSB, PUSH} state_t;

    state_t                 state;
    logic [ADDR_BITS-1:0]   fetch_pc;
    logic [DATA_BITS-1:0]   msb_byte;
    logic [15:0]            fifo_data [FIFO_DEPTH];
    logic [ADDR_BITS-1:0]   fifo_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic                   issue;
    logic                   pop;
    logic                   push;

    // One instruction in flight at most, so room now means room at PUSH.
    assign issue = !mem_busy && (count < DEPTH);
    assign pop   = inst_valid && inst_ready;
    assign push  = (state == PUSH);

    assign inst_valid = (count != '0);
    assign inst_data  = inst_valid ? fifo_data[rd_ptr] : '0;
    assign inst_pc    = inst_valid ? fifo_pc[rd_ptr]   : '0;

    always_comb begin
        rd_ram_en   = 1'b0;
        rd_ram_addr = '0;
        if (!redirect_en) begin
            case (state)
                REQ_MSB: if (issue) begin
                    rd_ram_en   = 1'b1;
                    rd_ram_addr = fetch_pc;
                end
                REQ_LSB: begin
                    rd_ram_en   = 1'b1;
                    rd_ram_addr = fetch_pc + PC_ONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            msb_byte <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else if (redirect_en) begin
            // Flush wins over any push/pop this cycle; in-flight pair is dropped.
            state    <= REQ_MSB;
            fetch_pc <= redirect_pc;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            case (state)
                IDLE:    state <= REQ_MSB;
                REQ_MSB: if (issue) state <= REQ_LSB;
                REQ_LSB: begin
                    msb_byte <= rd_ram_data;
                    state    <= PUSH;
                end
                PUSH: begin
                    fifo_data[wr_ptr] <= 16'({msb_byte, rd_ram_data});
                    fifo_pc[wr_ptr]   <= fetch_pc;
                    wr_ptr            <= wr_ptr + PTR_ONE;
                    fetch_pc          <= fetch_pc + PC_TWO;
                    state             <= REQ_MSB;
                end
                default: state <= IDLE;
            endcase
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end

endmodule
